// File: rtl/data_sram_bridge_if.sv
// Data-side SRAM-like bus between the bridge (master) and the memory slave.
// Signals:
//   data_req      master -> slave  request, held until data_addr_ok
//   data_wr       master -> slave  1 = write, 0 = read
//   data_size     master -> slave  0 = byte, 1 = half, 2 = word
//   data_addr     master -> slave  byte address
//   data_wstrb    master -> slave  byte strobes
//   data_wdata    master -> slave  write data
//   data_addr_ok  slave -> master  request accepted
//   data_data_ok  slave -> master  read data valid / write complete
//   data_rdata    slave -> master  read data
interface data_sram_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [3:0]            data_wstrb;
    logic [31:0]           data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [31:0]           data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Bridges MEM's single-cycle RAM port onto the request/addr_ok/data_ok bus and
// stalls the pipeline until the access completes (or the watchdog aborts it).
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   ram_en_i           MEM access request (held by MEM while stalled)
//   ram_write_en_i     byte strobes, 0000 = read
//   ram_addr_i         word-aligned address
//   ram_write_data_i   lane-aligned store data
//   ram_read_data_o    captured read word (0 for writes / aborts), valid in DONE
//   stall_req_o        combinational pipeline stall request
//   pipe_stall_in_i    pipeline held by another source; keeps us in DONE
//   bus_err_o          one-cycle pulse when the watchdog aborts an access
//   bus                data bus, master side
module data_sram_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_en_i,
    input  logic [3:0]            ram_write_en_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [31:0]           ram_write_data_i,
    output logic [31:0]           ram_read_data_o,
    output logic                  stall_req_o,
    input  logic                  pipe_stall_in_i,
    output logic                  bus_err_o,
    data_sram_bridge_if.master    bus
);
    // Counter must be able to hold TIMEOUT; keep at least one bit when disabled.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         wd_cnt_q, wd_cnt_d;

    logic in_bus;
    logic wd_hit;
    logic finish_ok;

    assign in_bus = (state_q == S_ADDR) || (state_q == S_DATA);
    // The counter holds the number of bus cycles already spent, so the cycle in
    // which it equals TIMEOUT-1 is the last one allowed.
    assign wd_hit = (TIMEOUT > 0) && in_bus && (wd_cnt_q == CW'(TIMEOUT - 1));
    assign finish_ok = ((state_q == S_ADDR) && bus.data_addr_ok && bus.data_data_ok) ||
                       ((state_q == S_DATA) && bus.data_data_ok);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Next-state logic. A completion in the watchdog's last cycle wins over abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (ram_en_i) state_d = S_ADDR;
            S_ADDR: begin
                if (finish_ok || wd_hit)    state_d = S_DONE;
                else if (bus.data_addr_ok)  state_d = S_DATA;
            end
            S_DATA: if (finish_ok || wd_hit) state_d = S_DONE;
            S_DONE: if (!pipe_stall_in_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        wd_cnt_d = wd_cnt_q;
        // Registered request: high exactly for the cycles spent in ADDR.
        req_d    = (state_d == S_ADDR);

        if (state_q == S_IDLE && ram_en_i) begin
            wr_d     = |ram_write_en_i;
            wstrb_d  = ram_write_en_i;
            wdata_d  = ram_write_data_i;
            addr_d   = ram_addr_i;
            size_d   = 2'd2;
            wd_cnt_d = '0;
            // Narrow stores: point the byte address at the lowest enabled lane.
            case (ram_write_en_i)
                4'b0000: ;
                4'b0001: begin size_d = 2'd0; addr_d[1:0] = 2'd0; end
                4'b0010: begin size_d = 2'd0; addr_d[1:0] = 2'd1; end
                4'b0100: begin size_d = 2'd0; addr_d[1:0] = 2'd2; end
                4'b1000: begin size_d = 2'd0; addr_d[1:0] = 2'd3; end
                4'b0011: begin size_d = 2'd1; addr_d[1:0] = 2'd0; end
                4'b1100: begin size_d = 2'd1; addr_d[1:0] = 2'd2; end
                default: addr_d[1:0] = 2'd0;
            endcase
        end

        if (in_bus) wd_cnt_d = wd_cnt_q + 1'b1;

        if (finish_ok) begin
            rdata_d = wr_q ? 32'd0 : bus.data_rdata;
        end else if (wd_hit) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
        end
    end

    assign stall_req_o     = rst && ram_en_i && (state_q != S_DONE);
    assign ram_read_data_o = rdata_q;
    assign bus_err_o       = err_q;
    assign bus.data_req    = req_q;
    assign bus.data_wr     = wr_q;
    assign bus.data_size   = size_q;
    assign bus.data_addr   = addr_q;
    assign bus.data_wstrb  = wstrb_q;
    assign bus.data_wdata  = wdata_q;
endmodule

// File: tb/tb_data_sram_bridge.sv
module tb_data_sram_bridge;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        stall_req;
    logic        pipe_stall_in;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    data_sram_bridge_if #(.ADDR_WIDTH(32)) bus_if ();

    data_sram_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .ram_en_i         (ram_en),
        .ram_write_en_i   (ram_we),
        .ram_addr_i       (ram_addr),
        .ram_write_data_i (ram_wdata),
        .ram_read_data_o  (ram_rdata),
        .stall_req_o      (stall_req),
        .pipe_stall_in_i  (pipe_stall_in),
        .bus_err_o        (bus_err),
        .bus              (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference request encoding, from lane arithmetic rather than a strobe table.
    function automatic void enc(input logic [3:0] we, input logic [31:0] addr,
                                output logic wr, output logic [1:0] sz, output logic [31:0] a);
        wr = |we;
        sz = 2'd2;
        a  = addr;
        if (wr) begin
            a[1:0] = 2'd0;
            if ($countones(we) == 1) begin
                sz = 2'd0;
                for (int i = 0; i < 4; i++) if (we[i]) a[1:0] = 2'(i);
            end else if (we == 4'b0011 || we == 4'b1100) begin
                sz = 2'd1;
                a[1:0] = we[0] ? 2'd0 : 2'd2;
            end
        end
    endfunction

    // One MEM access. Slave raises addr_ok on bus cycle a and data_ok on bus
    // cycle a+d (cycles counted from the first data_req cycle). Afterwards the
    // pipeline holds DONE for 'hold' extra cycles. Must be called at a negedge.
    task automatic txn(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int a, input int d, input int hold);
        logic xwr;
        logic [1:0] xsz;
        logic [31:0] xaddr, xrd, held;
        int bus_cyc, xreq, n_stall, n_req, n_err, k, cyc;
        bit abort, ok;

        enc(we, addr, xwr, xsz, xaddr);
        abort   = (a + d + 1) > TMO;
        bus_cyc = abort ? TMO : a + d + 1;
        xreq    = (a + 1 < bus_cyc) ? a + 1 : bus_cyc;
        xrd     = (xwr || abort) ? 32'd0 : rdata;

        ram_en = 1'b1; ram_we = we; ram_addr = addr; ram_wdata = wdata; pipe_stall_in = 1'b0;
        n_stall = 0; n_req = 0; n_err = 0; k = -1; cyc = 0;

        while (cyc < 60) begin
            #1;
            if (!stall_req) break;
            n_stall++;
            n_err += int'(bus_err);
            if (bus_if.data_req) begin
                n_req++;
                if (k < 0) begin
                    k = 0;
                    chk("wr", 32'(bus_if.data_wr), 32'(xwr));
                    chk("size", 32'(bus_if.data_size), 32'(xsz));
                    chk("addr", bus_if.data_addr, xaddr);
                    chk("wstrb", 32'(bus_if.data_wstrb), 32'(we));
                    if (xwr) chk("wdata", bus_if.data_wdata, wdata);
                end
            end
            if (k >= 0) begin
                bus_if.data_addr_ok = (k == a);
                bus_if.data_data_ok = (k == a + d);
                bus_if.data_rdata   = (k == a + d) ? rdata : $urandom;
                k++;
            end else begin
                // Stray responses while idle must be ignored.
                bus_if.data_addr_ok = 1'($urandom_range(0, 1));
                bus_if.data_data_ok = 1'($urandom_range(0, 1));
                bus_if.data_rdata   = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        chk("stall_bound", 32'(cyc < 60), 32'd1);

        chk("stall_cycles", n_stall, 1 + bus_cyc);
        chk("req_cycles", n_req, xreq);
        chk("err_in_bus", n_err, 0);
        chk("rdata", ram_rdata, xrd);
        chk("bus_err", 32'(bus_err), 32'(abort));

        held = ram_rdata;
        ok = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                #1;
                if (stall_req !== 1'b0 || bus_if.data_req !== 1'b0 ||
                    ram_rdata !== held || bus_err !== 1'b0) ok = 1'b0;
            end
            pipe_stall_in       = (h < hold);
            bus_if.data_addr_ok = 1'($urandom_range(0, 1));
            bus_if.data_data_ok = 1'($urandom_range(0, 1));
            bus_if.data_rdata   = $urandom;
            @(negedge clk);
        end
        if (hold > 0) chk("done_hold", 32'(ok), 32'd1);
        pipe_stall_in = 1'b0;
    endtask

    initial begin
        logic [3:0] we;
        int r, a, d;

        rst = 1'b0; ram_en = 1'b1; ram_we = 4'b1111; ram_addr = 32'h40; ram_wdata = 32'h1234_5678;
        pipe_stall_in = 1'b0;
        bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0; bus_if.data_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_req", 32'(bus_if.data_req), 32'd0);
        chk("rst_wr", 32'(bus_if.data_wr), 32'd0);
        chk("rst_size", 32'(bus_if.data_size), 32'd0);
        chk("rst_addr", bus_if.data_addr, 32'd0);
        chk("rst_wstrb", 32'(bus_if.data_wstrb), 32'd0);
        chk("rst_wdata", bus_if.data_wdata, 32'd0);
        chk("rst_rdata", ram_rdata, 32'd0);
        chk("rst_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b1; ram_en = 1'b0;
        @(negedge clk);

        // Directed cases
        txn(4'b0000, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);   // zero-wait read
        txn(4'b0100, 32'h200, 32'h00AB0000, 32'h0, 0, 0, 0);  // byte write
        txn(4'b0000, 32'h204, 32'h0, 32'hCAFEF00D, 3, 2, 0);  // split handshake
        txn(4'b0000, 32'h208, 32'h0, 32'h600DD00D, 1, 1, 4);  // external stall in DONE
        txn(4'b0000, 32'h20C, 32'h0, 32'h11111111, 40, 0, 2); // watchdog in ADDR
        txn(4'b0011, 32'h210, 32'h0000BEEF, 32'h0, 2, 40, 1); // watchdog in DATA
        txn(4'b0000, 32'h214, 32'h0, 32'h22222222, 3, 4, 0);  // completes on last allowed cycle
        txn(4'b0101, 32'h218, 32'h00FF00FF, 32'h0, 0, 1, 0);  // odd strobe -> word write

        // Reset while in DATA, then a late data_ok
        ram_en = 1'b1; ram_we = 4'b0000; ram_addr = 32'h300;
        bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
        @(negedge clk);
        #1;
        chk("rd_req_addr", 32'(bus_if.data_req), 32'd1);
        bus_if.data_addr_ok = 1'b1;
        @(negedge clk);
        #1;
        bus_if.data_addr_ok = 1'b0;
        chk("rd_req_data", 32'(bus_if.data_req), 32'd0);
        chk("rd_stall_data", 32'(stall_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst = 1'b1; ram_en = 1'b0;
        bus_if.data_data_ok = 1'b1; bus_if.data_rdata = 32'hBAADF00D;
        #1;
        chk("rst_mid_req", 32'(bus_if.data_req), 32'd0);
        chk("rst_mid_rdata", ram_rdata, 32'd0);
        @(negedge clk);
        bus_if.data_data_ok = 1'b0;
        #1;
        chk("late_ok_rdata", ram_rdata, 32'd0);
        chk("late_ok_stall", 32'(stall_req), 32'd0);
        chk("late_ok_req", 32'(bus_if.data_req), 32'd0);
        chk("late_ok_err", 32'(bus_err), 32'd0);
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: we = 4'b0000;
                3:       we = 4'(1 << $urandom_range(0, 3));
                4:       we = 4'b0011;
                5:       we = 4'b1100;
                6:       we = 4'b1111;
                default: we = 4'($urandom_range(1, 15));
            endcase
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom_range(0, 12); d = $urandom_range(0, 12);
            end else begin
                a = $urandom_range(0, 4);  d = $urandom_range(0, 4);
            end
            txn(we, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, a, d, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                ram_en = 1'b0;
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
